ucsbece152a_quad_decoder: RTL and testbench

Quadrature (A/B Gray-code) decoder that converts two asynchronous encoder lines into a step/direction command stream and a wrapping position count. It is the producing end of the step/direction interface used by the up/down counters in this design. It drives a counter's advance and direction controls directly, and also keeps its own position register for readback. It includes input synchronisation, an init phase, a transition state machine and illegal-transition detection.

---
 rtl/ucsbece152a_quad_decoder.sv | 177 +++++++++++++++++
 tb/tb_ucsbece152a_quad_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ucsbece152a_quad_decoder.sv
// Quadrature A/B decoder: synchronises the encoder lines and produces step/direction pulses,
// a wrapping position count and a sticky illegal-transition flag. Optional glitch filter: QUAD_FILTER_EN.
module ucsbece152a_quad_decoder #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             clr_i,
    output logic             step_o,
    output logic             dir_o,
    output logic [WIDTH-1:0] pos_o,
    output logic             err_o
);

    typedef enum logic {S_INIT, S_TRACK} state_t;

`ifdef QUAD_FILTER_EN
    localparam int unsigned INIT_LEN = SYNC_STAGES + FILTER_LEN;
`else
    localparam int unsigned INIT_LEN = SYNC_STAGES + 1;
`endif
    localparam int unsigned       CNT_W     = $clog2(INIT_LEN);
    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_LEN - 1);

    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic [1:0]             sync_val, cur;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       init_cnt_q, init_cnt_d;
    logic [1:0]             prev_q, prev_d;
    logic                   step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic [WIDTH-1:0]       pos_q, pos_d;
    logic [1:0]             delta;

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_i};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_i};
        end
    end

    assign sync_val = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef QUAD_FILTER_EN
    localparam int unsigned      FLT_W    = $clog2(FILTER_LEN);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    logic [1:0]       filt_q, filt_d, cand_q, cand_d;
    logic [FLT_W-1:0] fcnt_q, fcnt_d;

    // A zero count means no candidate is pending; the FILTER_LEN-th matching sample is accepted combinationally.
    always_comb begin
        filt_d = filt_q;
        cand_d = cand_q;
        fcnt_d = fcnt_q;
        if (sync_val == filt_q) begin
            fcnt_d = '0;
        end else if (sync_val == cand_q && fcnt_q != '0) begin
            if (fcnt_q == FLT_LAST) begin
                filt_d = sync_val;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + FLT_W'(1);
            end
        end else begin
            cand_d = sync_val;
            fcnt_d = FLT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            cand_q <= '0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            cand_q <= cand_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign cur = filt_d;
`else
    assign cur = sync_val;
`endif

    // Map Gray code onto a 0..3 ring index: +1 is forward, -1 reverse, 2 is a double-bit jump.
    function automatic logic [1:0] gray_idx(input logic [1:0] v);
        return {v[1], v[1] ^ v[0]};
    endfunction

    assign delta = gray_idx(cur) - gray_idx(prev_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) state_d = S_TRACK;
                else                         init_cnt_d = init_cnt_q + CNT_W'(1);
            end
            default: state_d = S_TRACK;
        endcase
    end

    always_comb begin
        step_d = 1'b0;
        dir_d  = dir_q;
        pos_d  = pos_q;
        err_d  = err_q;
        prev_d = prev_q;
        if (state_q == S_INIT) begin
            if (init_cnt_q == INIT_LAST) prev_d = cur;
        end else begin
            prev_d = cur;
            case (delta)
                2'd1: begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    pos_d  = pos_q + WIDTH'(1);
                end
                2'd3: begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    pos_d  = pos_q - WIDTH'(1);
                end
                2'd2:    err_d = 1'b1;
                default: ;
            endcase
        end
        if (clr_i) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 2'b00;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
            pos_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            step_q <= step_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
            err_q  <= err_d;
        end
    end

    assign step_o = step_q;
    assign dir_o  = dir_q;
    assign pos_o  = pos_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_ucsbece152a_quad_decoder.sv
// Directed bench for ucsbece152a_quad_decoder (WIDTH=3, SYNC_STAGES=2); runs the filter vectors when QUAD_FILTER_EN is defined.
module tb_ucsbece152a_quad_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_i = 1'b0;
    logic       b_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       step_o, dir_o, err_o;
    logic [2:0] pos_o;

    int n_cmp = 0;
    int n_bad = 0;

    ucsbece152a_quad_decoder #(.WIDTH(3), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_i    (a_i),
        .b_i    (b_i),
        .clr_i  (clr_i),
        .step_o (step_o),
        .dir_o  (dir_o),
        .pos_o  (pos_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_ab(input logic [1:0] v);
        a_i = v[1];
        b_i = v[0];
    endtask

    task automatic do_reset(input logic [1:0] v, input string tag);
        set_ab(v);
        clr_i = 1'b0;
        rst   = 1'b1;
        #1;
        check({tag, "_rst_pos"}, 32'(pos_o), 0);
        check({tag, "_rst_dir"}, 32'(dir_o), 0);
        check({tag, "_rst_step"}, 32'(step_o), 0);
        check({tag, "_rst_err"}, 32'(err_o), 0);
        ticks(2);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_window(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen = seen | step_o;
        end
        check({tag, "_no_step"}, 32'(seen), 0);
    endtask

    // Change the inputs and expect a single step pulse exactly `lat` edges later.
    task automatic move(input logic [1:0] v, input logic exp_dir, input logic [2:0] exp_pos,
                        input int lat, input int gap, input string tag);
        set_ab(v);
        ticks(lat - 1);
        check({tag, "_early"}, 32'(step_o), 0);
        tick();
        check({tag, "_step"}, 32'(step_o), 1);
        check({tag, "_dir"}, 32'(dir_o), 32'(exp_dir));
        check({tag, "_pos"}, 32'(pos_o), 32'(exp_pos));
        tick();
        check({tag, "_pulse_end"}, 32'(step_o), 0);
        if (gap > lat + 1) ticks(gap - lat - 1);
    endtask

    logic [1:0] fwd_seq [9] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [2:0] fwd_pos [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    initial begin
`ifdef QUAD_FILTER_EN
        do_reset(2'b11, "f_init11");
        idle_window(14, "f_init11");
        check("f_init11_err", 32'(err_o), 0);

        do_reset(2'b00, "f_init00");
        ticks(8);
        set_ab(2'b10);
        ticks(2);
        set_ab(2'b00);
        idle_window(12, "f_glitch");
        check("f_glitch_err", 32'(err_o), 0);
        check("f_glitch_pos", 32'(pos_o), 0);

        move(2'b10, 1'b1, 3'd7, 6, 10, "f_stable");
        check("f_stable_err", 32'(err_o), 0);
`else
        // Inputs high through reset must not produce a phantom step.
        do_reset(2'b11, "init11");
        idle_window(10, "init11");
        check("init11_err", 32'(err_o), 0);
        check("init11_pos", 32'(pos_o), 0);

        do_reset(2'b00, "init00");
        ticks(5);
        for (int i = 0; i < 9; i++) move(fwd_seq[i], 1'b0, fwd_pos[i], 3, 8, $sformatf("fwd%0d", i));

        move(2'b00, 1'b1, 3'd0, 3, 8, "rev0");
        move(2'b10, 1'b1, 3'd7, 3, 8, "rev1");
        move(2'b11, 1'b1, 3'd6, 3, 8, "rev2");

        set_ab(2'b00);
        idle_window(8, "illegal");
        check("illegal_err", 32'(err_o), 1);
        check("illegal_pos", 32'(pos_o), 6);
        check("illegal_dir", 32'(dir_o), 1);
        ticks(10);
        check("illegal_sticky", 32'(err_o), 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_err", 32'(err_o), 0);
        check("clr_pos", 32'(pos_o), 0);

        for (int i = 0; i < 5; i++) move(fwd_seq[i], 1'b0, fwd_pos[i], 3, 8, $sformatf("pre_clr%0d", i));
        set_ab(2'b11);
        ticks(2);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_step_step", 32'(step_o), 1);
        check("clr_step_dir", 32'(dir_o), 0);
        check("clr_step_pos", 32'(pos_o), 0);
        tick();
        check("clr_step_end", 32'(step_o), 0);

        move(2'b01, 1'b1, 3'd7, 3, 8, "pre_rst");
        do_reset(2'b01, "mid");
        idle_window(10, "mid");
        check("mid_pos", 32'(pos_o), 0);
        check("mid_err", 32'(err_o), 0);

        // Consecutive-cycle transitions each give their own pulse.
        set_ab(2'b11);
        tick();
        set_ab(2'b10);
        tick();
        check("b2b_early", 32'(step_o), 0);
        tick();
        check("b2b_step1", 32'(step_o), 1);
        check("b2b_pos1", 32'(pos_o), 1);
        tick();
        check("b2b_step2", 32'(step_o), 1);
        check("b2b_pos2", 32'(pos_o), 2);
        check("b2b_dir", 32'(dir_o), 0);
        tick();
        check("b2b_end", 32'(step_o), 0);
        check("b2b_hold", 32'(pos_o), 2);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
